// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Op encodings, FSM state constants and default datapath sizes.
package shift_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_stage.sv
// Single combinational shift step of 1 or 2 bits.
// The only shifting logic in the sequencer.
module shift_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       op,
    input  logic [1:0]       step,
    output logic [WIDTH-1:0] shifted
);

    import shift_pkg::*;

    // Apply one step in the direction and fill mode selected by op
    always_comb begin
        shifted = value;
        unique case (op)
            OP_SLL:  shifted = value << step;
            OP_SRL:  shifted = value >> step;
            OP_SRA:  shifted = $signed(value) >>> step;
            default: shifted = value;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle SLL/SRL/SRA sequencer: 2 bits per cycle, 1 bit for an odd tail.
// Pipeline stalls on busy and captures result on done.
module shift_seq #(
    parameter int WIDTH = shift_pkg::WIDTH,
    parameter int SHW   = shift_pkg::SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    import shift_pkg::*;

    logic [1:0]       state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [1:0]       kind, kind_n;
    logic [WIDTH-1:0] res_n;
    logic [1:0]       step;
    logic [WIDTH-1:0] staged;
    logic             accept;

    assign step = (cnt >= SHW'(2)) ? 2'd2 : 2'd1;

    assign accept = start && !abort &&
                    (state == ST_IDLE || state == ST_DONE);

    shift_stage #(.WIDTH(WIDTH)) u_stage (
        .value   (acc),
        .op      (kind),
        .step    (step),
        .shifted (staged)
    );

    // Next-state logic: abort beats accept, accept beats the running op
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        kind_n  = kind;
        res_n   = result;
        if (abort) begin
            state_n = ST_IDLE;
        end else if (accept) begin
            acc_n  = operand;
            cnt_n  = shamt;
            kind_n = op;
            if (shamt == '0 || op == OP_RSVD) begin
                state_n = ST_DONE;
                res_n   = operand;
            end else begin
                state_n = ST_SHIFT;
            end
        end else begin
            unique case (state)
                ST_SHIFT: begin
                    acc_n = staged;
                    cnt_n = cnt - SHW'(step);
                    if (cnt_n == '0) begin
                        state_n = ST_DONE;
                        res_n   = staged;
                    end
                end
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            cnt    <= '0;
            kind   <= OP_SLL;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            cnt    <= cnt_n;
            kind   <= kind_n;
            result <= res_n;
            busy   <= (state_n == ST_SHIFT);
            done   <= (state_n == ST_DONE);
        end
    end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift sequencer for the execute stage: accepts an operand, a shift amount and a shift kind, and produces the shifted result by applying a fixed 2-bit stage per cycle, or a 1-bit stage for the final odd bit. It replaces a full barrel shifter for SLL/SRL/SRA, including variable-amount forms. The pipeline controller stalls on `busy` and captures `result` on `done`.

## Interface
- `WIDTH`, 32: datapath width.
- `SHW`, 5: shift-amount width; must equal clog2(`WIDTH`).
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request; accepted only when the block is idle or in DONE.
- `abort` in 1: synchronous cancel; used on pipeline flush.
- `op` in 2: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- `operand` in `WIDTH`: value to shift; sampled on accept.
- `shamt` in `SHW`: shift amount; sampled on accept.
- `busy` out 1: high while shifting.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out `WIDTH`: shifted value; held until the next accept or reset.

## Operation
- Reset (`rst_n`=0 at an edge):
  - state IDLE;
  - `busy`=0, `done`=0, `result`=0;
  - internal accumulator and counter cleared.
- States:
  - IDLE: `busy`=0, `done`=0.
  - SHIFT: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- Accept condition: `start`=1, `abort`=0, state IDLE or DONE. On accept:
  - accumulator ← `operand`; counter ← `shamt`; kind ← `op`.
  - If `shamt`==0 or `op`==11: next state DONE, `result` = `operand` unchanged.
  - Otherwise: next state SHIFT.
- SHIFT, each cycle:
  - step = 2 if counter ≥ 2, else 1.
  - Accumulator shifted by step:
    - SLL: zeros into the LSBs.
    - SRL: zeros into the MSBs.
    - SRA: copies of bit `WIDTH`-1 into the MSBs.
  - counter ← counter − step.
  - When the new counter is 0: next state DONE.
- DONE:
  - `result` = accumulator.
  - With no accept: next state IDLE; `result` keeps its value.
  - With an accept: next state follows the accept rules (back-to-back operation).
- `start` in SHIFT is ignored; there is no queuing.
- `abort`=1 at an edge, in any state:
  - next state IDLE; `done` not asserted; `result` unchanged.
  - Has priority over a simultaneous `start`.
- `rst_n` has priority over everything, including mid-operation.
- Reserved `op` 11 is a pass-through with latency 1; no error flag.

## Timing
- Latency, counted from the accepting edge to the cycle in which `done`=1: ceil(`shamt`/2)+1 cycles.
  - `shamt`=0 → 1 cycle.
  - `shamt`=1 → 2 cycles.
  - `shamt`=2 → 2 cycles.
  - `shamt`=31 → 17 cycles.
- `busy` rises in the cycle after the accepting edge; it is not combinational from `start`.
- Throughput: a new operation may be accepted in the DONE cycle, giving no idle bubble.
- `done` and `busy` are never high together.
- All outputs are registered.

## Structure
- Shared package `shift_pkg`:
  - op encodings `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_RSVD`;
  - state enum IDLE/SHIFT/DONE;
  - parameters `WIDTH` and `SHW`.
- Sub-module `shift_stage`: combinational single step.
  - Inputs: value, op, step (1 or 2).
  - Output: shifted value.
  - Instantiated once; it is the only shifting logic in the block.
- Top level: FSM, counter, accumulator and output registers.

## Test plan
- Reset mid-SHIFT: accept SLL `operand`=0x0000_0001, `shamt`=20; drop `rst_n` at cycle 4 → next cycle `busy`=0, `done`=0, `result`=0; no later `done`.
- SLL `operand`=0x0000_0001, `shamt`=31 → `busy` high for 16 cycles, then `done` with `result`=0x8000_0000 at latency 17.
- SRA `operand`=0x8000_0000, `shamt`=3 → `done` at latency 3, `result`=0xF000_0000. SRL, same inputs → `result`=0x1000_0000.
- `shamt`=0 and `op`=11 cases, `operand`=0xDEAD_BEEF → `done` at latency 1, `result`=0xDEAD_BEEF, `busy` never high.
- Back-to-back: second `start` (SRL 0xFF00_0000, `shamt`=8) presented in the first op's DONE cycle → accepted; second `done` 5 cycles later with `result`=0x00FF_0000. A `start` during SHIFT is ignored.
- `abort` together with `start` in IDLE → no accept. `abort` mid-SHIFT → IDLE next cycle, no `done`, `result` holds its prior value.
